arp_learn: RTL and testbench

- Writer side of the ARP table. Takes (IP, MAC) bindings already parsed from received ARP replies and requests and installs them into the ARP CAM/LUT.
- Drives the table's write port: arp_wr_addr, arp_wr_req, arp_wr_mac, arp_wr_ip, arp_wr_ack.
- Keeps a shadow copy of the installed IPs. This lets it refresh an existing entry in place, allocate a free slot, or evict round-robin.
- Sits in the user datapath beside the ARP lookup block, downstream of the ARP packet parser.

---
 rtl/arp_learn_pkg.sv | 18 +
 rtl/arp_shadow_search.sv | 66 ++++++
 rtl/arp_learn.sv | 188 ++++++++++++++++++
 tb/tb_arp_learn.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/arp_learn_pkg.sv
// Shared encodings and defaults for the ARP table writer and its shadow search.
package arp_learn_pkg;

    localparam int unsigned LUT_DEPTH_DEFAULT = 32;
    localparam int unsigned MAC_MCAST_BIT     = 40;

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StWrite
    } state_e;

    typedef enum logic {
        KindNew,
        KindUpdate
    } kind_e;

endpackage

// File: rtl/arp_shadow_search.sv
// Shadow copy of installed ARP bindings: parallel IP match plus lowest-free-slot encoder.
module arp_shadow_search
    import arp_learn_pkg::*;
#(
    parameter int unsigned DEPTH = LUT_DEPTH_DEFAULT,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_ip,
    input  logic [47:0]      wr_mac,
    input  logic [31:0]      search_ip,
    input  logic [47:0]      search_mac,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx,
    output logic             hit_mac_eq,
    output logic             free,
    output logic [IDX_W-1:0] free_idx
);

    logic [DEPTH-1:0] valid_q;
    logic [31:0]      ip_q  [DEPTH];
    logic [47:0]      mac_q [DEPTH];

    // Flush beats a coincident write so the entry stays invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ip_q[wr_idx]  <= wr_ip;
            mac_q[wr_idx] <= wr_mac;
        end
    end

    // Descending scan so the lowest matching index wins.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        hit_mac_eq = 1'b0;
        free       = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (ip_q[i] == search_ip)) begin
                hit        = 1'b1;
                hit_idx    = IDX_W'(i);
                hit_mac_eq = (mac_q[i] == search_mac);
            end
            if (!valid_q[i]) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/arp_learn.sv
// ARP table writer: installs learned (IP, MAC) bindings, refreshing, allocating or evicting.
module arp_learn
    import arp_learn_pkg::*;
#(
    parameter int unsigned LUT_DEPTH      = LUT_DEPTH_DEFAULT,
    parameter int unsigned LUT_DEPTH_BITS = $clog2(LUT_DEPTH),
    parameter int unsigned ACK_TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               learn_ip,
    input  logic [47:0]               learn_mac,
    input  logic                      learn_vld,
    output logic                      learn_rdy,
    input  logic                      flush,
    output logic [LUT_DEPTH_BITS-1:0] arp_wr_addr,
    output logic                      arp_wr_req,
    output logic [47:0]               arp_wr_mac,
    output logic [31:0]               arp_wr_ip,
    input  logic                      arp_wr_ack,
    output logic [31:0]               num_learned,
    output logic [31:0]               num_updated,
    output logic [31:0]               num_dropped,
    output logic [31:0]               num_timeouts
);

    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    state_e                    state_q, state_d;
    kind_e                     kind_q, kind_d;
    logic                      evict_q, evict_d;
    logic [31:0]               ip_q, ip_d;
    logic [47:0]               mac_q, mac_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic [LUT_DEPTH_BITS-1:0] victim_q, victim_d;
    logic [LUT_DEPTH_BITS-1:0] addr_q, addr_d;
    logic                      req_q, req_d;
    logic [47:0]               wmac_q, wmac_d;
    logic [31:0]               wip_q, wip_d;
    logic [31:0]               learned_q, learned_d, updated_q, updated_d;
    logic [31:0]               dropped_q, dropped_d, timeouts_q, timeouts_d;

    logic                      hit, hit_mac_eq, free, shadow_we, drop;
    logic [LUT_DEPTH_BITS-1:0] hit_idx, free_idx;

    arp_shadow_search #(
        .DEPTH (LUT_DEPTH),
        .IDX_W (LUT_DEPTH_BITS)
    ) u_shadow (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .wr_en      (shadow_we),
        .wr_idx     (addr_q),
        .wr_ip      (wip_q),
        .wr_mac     (wmac_q),
        .search_ip  (ip_q),
        .search_mac (mac_q),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .hit_mac_eq (hit_mac_eq),
        .free       (free),
        .free_idx   (free_idx)
    );

    assign drop = (ip_q == '0) || (mac_q == '0) || mac_q[MAC_MCAST_BIT];

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        evict_d    = evict_q;
        ip_d       = ip_q;
        mac_d      = mac_q;
        timer_d    = timer_q;
        victim_d   = victim_q;
        addr_d     = addr_q;
        req_d      = req_q;
        wmac_d     = wmac_q;
        wip_d      = wip_q;
        learned_d  = learned_q;
        updated_d  = updated_q;
        dropped_d  = dropped_q;
        timeouts_d = timeouts_q;
        shadow_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (learn_vld) begin
                    ip_d    = learn_ip;
                    mac_d   = learn_mac;
                    state_d = StSearch;
                end
            end
            StSearch: begin
                if (drop || (hit && hit_mac_eq)) begin
                    dropped_d = dropped_q + 32'd1;
                    state_d   = StIdle;
                end else begin
                    if (hit) begin
                        addr_d  = hit_idx;
                        kind_d  = KindUpdate;
                        evict_d = 1'b0;
                    end else if (free) begin
                        addr_d  = free_idx;
                        kind_d  = KindNew;
                        evict_d = 1'b0;
                    end else begin
                        addr_d  = victim_q;
                        kind_d  = KindNew;
                        evict_d = 1'b1;
                    end
                    wip_d   = ip_q;
                    wmac_d  = mac_q;
                    req_d   = 1'b1;
                    timer_d = '0;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (arp_wr_ack) begin
                    req_d     = 1'b0;
                    shadow_we = 1'b1;
                    if (kind_q == KindUpdate) updated_d = updated_q + 32'd1;
                    else                      learned_d = learned_q + 32'd1;
                    if (evict_q) begin
                        victim_d = (victim_q == LUT_DEPTH_BITS'(LUT_DEPTH - 1)) ? '0
                                                                               : victim_q + 1'b1;
                    end
                    state_d = StIdle;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    req_d      = 1'b0;
                    timeouts_d = timeouts_q + 32'd1;
                    state_d    = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) victim_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            kind_q     <= KindNew;
            evict_q    <= 1'b0;
            ip_q       <= '0;
            mac_q      <= '0;
            timer_q    <= '0;
            victim_q   <= '0;
            addr_q     <= '0;
            req_q      <= 1'b0;
            wmac_q     <= '0;
            wip_q      <= '0;
            learned_q  <= '0;
            updated_q  <= '0;
            dropped_q  <= '0;
            timeouts_q <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            evict_q    <= evict_d;
            ip_q       <= ip_d;
            mac_q      <= mac_d;
            timer_q    <= timer_d;
            victim_q   <= victim_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            wmac_q     <= wmac_d;
            wip_q      <= wip_d;
            learned_q  <= learned_d;
            updated_q  <= updated_d;
            dropped_q  <= dropped_d;
            timeouts_q <= timeouts_d;
        end
    end

    assign learn_rdy    = (state_q == StIdle) && !reset;
    assign arp_wr_addr  = addr_q;
    assign arp_wr_req   = req_q;
    assign arp_wr_mac   = wmac_q;
    assign arp_wr_ip    = wip_q;
    assign num_learned  = learned_q;
    assign num_updated  = updated_q;
    assign num_dropped  = dropped_q;
    assign num_timeouts = timeouts_q;

endmodule

// File: tb/tb_arp_learn.sv
// Scoreboard bench for arp_learn: expected table writes queued at stimulus, checked at arp_wr_req.
module tb_arp_learn;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] learn_ip;
    logic [47:0] learn_mac;
    logic        learn_vld;
    logic        learn_rdy;
    logic        flush;
    logic [4:0]  arp_wr_addr;
    logic        arp_wr_req;
    logic [47:0] arp_wr_mac;
    logic [31:0] arp_wr_ip;
    logic        arp_wr_ack;
    logic [31:0] num_learned, num_updated, num_dropped, num_timeouts;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] ip;
        logic [47:0] mac;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    logic prev_req = 1'b0;

    always #5 clk = ~clk;

    arp_learn dut (
        .clk          (clk),
        .reset        (reset),
        .learn_ip     (learn_ip),
        .learn_mac    (learn_mac),
        .learn_vld    (learn_vld),
        .learn_rdy    (learn_rdy),
        .flush        (flush),
        .arp_wr_addr  (arp_wr_addr),
        .arp_wr_req   (arp_wr_req),
        .arp_wr_mac   (arp_wr_mac),
        .arp_wr_ip    (arp_wr_ip),
        .arp_wr_ack   (arp_wr_ack),
        .num_learned  (num_learned),
        .num_updated  (num_updated),
        .num_dropped  (num_dropped),
        .num_timeouts (num_timeouts)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every rising arp_wr_req must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            prev_req <= 1'b0;
        end else begin
            if (arp_wr_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    check("spurious_write", 64'd1, 64'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(arp_wr_addr), 64'(e.addr));
                    check("wr_ip", 64'(arp_wr_ip), 64'(e.ip));
                    check("wr_mac", 64'(arp_wr_mac), 64'(e.mac));
                end
            end
            prev_req <= arp_wr_req;
        end
    end

    task automatic check_counters(input int l, input int u, input int d, input int t);
        check("num_learned", 64'(num_learned), 64'(l));
        check("num_updated", 64'(num_updated), 64'(u));
        check("num_dropped", 64'(num_dropped), 64'(d));
        check("num_timeouts", 64'(num_timeouts), 64'(t));
    endtask

    // ack_dly: cycles between arp_wr_req rising and ack; negative means never ack.
    task automatic learn(input logic [31:0] ip, input logic [47:0] mac, input bit wr,
                         input logic [4:0] addr, input int ack_dly, input bit fl);
        int n = 0;
        while (!learn_rdy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rdy_before", 64'(learn_rdy), 64'd1);
        learn_ip  = ip;
        learn_mac = mac;
        learn_vld = 1'b1;
        if (wr) exp_q.push_back('{addr: addr, ip: ip, mac: mac});
        @(negedge clk);
        learn_vld = 1'b0;
        check("rdy_search", 64'(learn_rdy), 64'd0);
        @(negedge clk);
        check("req_t2", 64'(arp_wr_req), 64'(wr));
        if (!wr) begin
            check("rdy_after_drop", 64'(learn_rdy), 64'd1);
        end else if (ack_dly >= 0) begin
            for (int i = 0; i < ack_dly; i++) begin
                check("req_held", 64'(arp_wr_req), 64'd1);
                @(negedge clk);
            end
            arp_wr_ack = 1'b1;
            flush      = fl;
            @(negedge clk);
            arp_wr_ack = 1'b0;
            flush      = 1'b0;
            check("req_drop_after_ack", 64'(arp_wr_req), 64'd0);
            check("rdy_a1", 64'(learn_rdy), 64'd1);
        end else begin
            n = 0;
            while (arp_wr_req && n < 400) begin
                @(negedge clk);
                n++;
            end
            check("timeout_len", 64'(n), 64'd255);
            check("rdy_after_to", 64'(learn_rdy), 64'd1);
        end
    endtask

    initial begin
        reset      = 1'b1;
        learn_ip   = '0;
        learn_mac  = '0;
        learn_vld  = 1'b0;
        flush      = 1'b0;
        arp_wr_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdy", 64'(learn_rdy), 64'd0);
        check("rst_req", 64'(arp_wr_req), 64'd0);
        check("rst_addr", 64'(arp_wr_addr), 64'd0);
        check_counters(0, 0, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rdy_post_reset", 64'(learn_rdy), 64'd1);

        learn(32'h0a000001, 48'h001122334455, 1'b1, 5'd0, 3, 1'b0);
        check_counters(1, 0, 0, 0);
        learn(32'h0a000001, 48'h001122334455, 1'b0, 5'd0, 0, 1'b0);
        check_counters(1, 0, 1, 0);
        learn(32'h0a000001, 48'h001122334466, 1'b1, 5'd0, 1, 1'b0);
        check_counters(1, 1, 1, 0);

        learn(32'h00000000, 48'h001122334477, 1'b0, 5'd0, 0, 1'b0);
        learn(32'h0a000009, 48'hffffffffffff, 1'b0, 5'd0, 0, 1'b0);
        learn(32'h0a000009, 48'h01005e000001, 1'b0, 5'd0, 0, 1'b0);
        check_counters(1, 1, 4, 0);

        for (int i = 1; i < 32; i++) begin
            learn({24'h0a0001, 8'(i)}, {24'h001122, 24'(i)}, 1'b1, 5'(i), 0, 1'b0);
        end
        check_counters(32, 1, 4, 0);
        for (int k = 0; k < 3; k++) begin
            learn({24'h0a0002, 8'(k)}, {24'h00aabb, 24'(k)}, 1'b1, 5'(k), 2, 1'b0);
        end
        check_counters(35, 1, 4, 0);

        // Timeout leaves the shadow and victim pointer alone, so the retry lands on slot 3 again.
        learn(32'h0a000301, 48'h0000cafe0001, 1'b1, 5'd3, -1, 1'b0);
        check_counters(35, 1, 4, 1);
        learn(32'h0a000301, 48'h0000cafe0001, 1'b1, 5'd3, 0, 1'b0);
        check_counters(36, 1, 4, 1);

        learn(32'h0a000401, 48'h0000beef0001, 1'b1, 5'd4, 1, 1'b1);
        check_counters(37, 1, 4, 1);
        learn(32'h0a000501, 48'h0000beef0002, 1'b1, 5'd0, 0, 1'b0);
        learn(32'h0a000401, 48'h0000beef0001, 1'b1, 5'd1, 0, 1'b0);
        check_counters(39, 1, 4, 1);

        // Reset while a write is outstanding.
        learn_ip  = 32'h0a000601;
        learn_mac = 48'h0000beef0003;
        learn_vld = 1'b1;
        exp_q.push_back('{addr: 5'd2, ip: 32'h0a000601, mac: 48'h0000beef0003});
        @(negedge clk);
        learn_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("req_before_reset", 64'(arp_wr_req), 64'd1);
        reset = 1'b1;
        #1;
        check("req_in_reset", 64'(arp_wr_req), 64'd0);
        check("rdy_in_reset", 64'(learn_rdy), 64'd0);
        check_counters(0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rdy_end", 64'(learn_rdy), 64'd1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
